// File: rtl/sopc_run_ctrl_if.sv
// Data-memory write port as seen by the run controller's halt monitor.
`timescale 1ns/1ps
interface sopc_run_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              mon_we;
    logic [ADDR_W-1:0] mon_addr;
    logic [DATA_W-1:0] mon_wdata;

    modport master (output mon_we, output mon_addr, output mon_wdata);
    modport slave  (input  mon_we, input  mon_addr, input  mon_wdata);
endinterface

// File: rtl/sopc_run_ctrl.sv
// Run controller: sequences core reset, counts run cycles, ends the run on a halt-address
// write or a watchdog timeout, and holds pass/timeout/exit-code status until re-run.
`timescale 1ns/1ps
module sopc_run_ctrl #(
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       DATA_W          = 32,
    parameter int unsigned       CNT_W           = 32,
    parameter int unsigned       RST_HOLD_CYCLES = 8,
    parameter int unsigned       TIMEOUT_CYCLES  = 50000,
    parameter logic [ADDR_W-1:0] HALT_ADDR       = 32'h0000_1000,
    parameter bit                AUTO_START      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sopc_run_ctrl_if.slave    mon,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              core_rst_d, running_d, done_d, pass_d, timeout_d;
    logic [DATA_W-1:0] exit_code_d;
    logic [CNT_W-1:0]  cycle_count_d;
    logic              go_hold, halt_hit, tmo_hit, hold_last;

    assign halt_hit  = mon.mon_we && (mon.mon_addr == HALT_ADDR);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) &&
                       (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign hold_last = (hold_q == HOLD_W'(RST_HOLD_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        core_rst_d    = core_rst;
        running_d     = running;
        done_d        = done;
        pass_d        = pass;
        timeout_d     = timeout;
        exit_code_d   = exit_code;
        cycle_count_d = cycle_count;
        go_hold       = 1'b0;

        unique case (state_q)
            StIdle: go_hold = AUTO_START || start;
            StHold: begin
                if (hold_last) begin
                    state_d    = StRun;
                    core_rst_d = 1'b0;
                    running_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            StRun: begin
                // Halt takes priority over a coincident watchdog expiry.
                if (halt_hit) begin
                    state_d     = StDone;
                    core_rst_d  = 1'b1;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = (mon.mon_wdata == '0);
                    timeout_d   = 1'b0;
                    exit_code_d = mon.mon_wdata;
                end else if (tmo_hit) begin
                    state_d     = StDone;
                    core_rst_d  = 1'b1;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b1;
                    exit_code_d = '1;
                end else if (cycle_count != '1) begin
                    cycle_count_d = cycle_count + CNT_W'(1);
                end
            end
            StDone: go_hold = start;
            default: state_d = StIdle;
        endcase

        if (go_hold) begin
            state_d       = StHold;
            hold_d        = '0;
            core_rst_d    = 1'b1;
            running_d     = 1'b0;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            timeout_d     = 1'b0;
            exit_code_d   = '0;
            cycle_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            core_rst    <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            core_rst    <= core_rst_d;
            running     <= running_d;
            done        <= done_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
            exit_code   <= exit_code_d;
            cycle_count <= cycle_count_d;
        end
    end

endmodule
